// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: 2-flop synchronized rx, start/data/stop sampling at bit centres.
// Optional 8E1 framing with parity checking when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic            rx_m;
    logic            rx_s;
    logic            armed;
    logic [2:0]      bit_idx;
    logic [CW-1:0]   cnt;
    logic [7:0]      shreg;
`ifdef UART_RX_PARITY_EN
    logic            par_acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            armed      <= 1'b0;
            bit_idx    <= 3'd0;
            cnt        <= '0;
            shreg      <= 8'h00;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc    <= 1'b0;
`endif
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            case (state)
                IDLE: begin
                    // A start edge only counts after the line has been seen high.
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        armed <= 1'b0;
                        busy  <= 1'b1;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == CW'(H - 1)) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
`ifdef UART_RX_PARITY_EN
                        par_acc        <= par_acc ^ rx_s;
`endif
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt     <= '0;
                        par_acc <= par_acc ^ rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif

                STOP: begin
                    if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_acc) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: bit-level rx driver, strobe scoreboard, busy/reset checks.
// Build with UART_RX_PARITY_EN defined to include the 8E1 parity scenarios.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Pin fall -> 2 sync flops -> half bit -> remaining bits to stop sample -> registered strobe.
    localparam int LATENCY = 2 + CPB / 2 + NBITS * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: items are {data_valid, frame_err, parity_err, data_out}
    logic [10:0] exp_q[$];
    logic [10:0] exp_item;
    logic [7:0]  last_good = 8'h00;
    int          compared = 0;
    int          mismatched = 0;
    int          fall_cyc = 0;
    int          last_strobe_cyc = -1;
    int          n0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (data_valid || frame_err || parity_err)) begin
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, data_valid, frame_err, parity_err}, 32'd0);
            end else begin
                exp_item = exp_q.pop_front();
                chk("strobe", {21'd0, data_valid, frame_err, parity_err, data_out}, {21'd0, exp_item});
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        fall_cyc = cyc;
        for (int i = 0; i < n; i++) drive_bit(bits[i]);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        if (!stop) begin
            exp_q.push_back({3'b010, last_good});
        end else if (!par_ok) begin
            exp_q.push_back({3'b001, last_good});
        end else begin
            exp_q.push_back({3'b100, d});
            last_good = d;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        expect_frame(d, stop, 1'b1);
`ifdef UART_RX_PARITY_EN
        send_bits({stop, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop, d, 1'b0}, 10);
`endif
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic stop, input logic par);
        expect_frame(d, stop, ~((^d) ^ par));
        send_bits({stop, par, d, 1'b0}, 11);
    endtask
`endif

    initial begin
        // reset values
        tick(3);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_parity_err", parity_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(2 * CPB);

        // clean byte with exact strobe latency from the pin falling edge
        send_frame(8'hA5, 1'b1);
        tick(CPB);
        chk("clean_latency", last_strobe_cyc - fall_cyc, LATENCY);

        // framing error, then a long break that must not retrigger
        send_frame(8'h5A, 1'b0);
        rx = 1'b0;
        tick(20 * CPB);
        chk("busy_during_break", busy, 1'b0);
        tick(20 * CPB);
        rx = 1'b1;
        tick(2 * CPB);

        // start glitch: 4 low cycles, rejected at the half-bit check
        n0 = cyc;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        wait_until(n0 + 10);
        chk("glitch_busy_before_check", busy, 1'b1);
        wait_until(n0 + 11);
        chk("glitch_busy_after_check", busy, 1'b0);
        tick(2 * CPB);
        send_frame(8'h3C, 1'b1);

        // back-to-back with zero idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(2 * CPB);

        // reset in the middle of data bit 4 of 0xC3
        send_bits({6'd0, 4'h3, 1'b0}, 5);
        rx = 1'b0;
        tick(CPB / 2);
        chk("busy_mid_frame", busy, 1'b1);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        reset = 1'b0;
        last_good = 8'h00;
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_data_valid", data_valid, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);
        chk("midrst_parity_err", parity_err, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        tick(2 * CPB);
        send_frame(8'h7E, 1'b1);
        tick(2 * CPB);

`ifdef UART_RX_PARITY_EN
        send_frame_par(8'h03, 1'b1, 1'b0);
        send_frame_par(8'h03, 1'b1, 1'b1);
        tick(2 * CPB);
`endif

        chk("final_data_out", data_out, last_good);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("FAIL watchdog: observed cycle %0d expected run to finish", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive-side deserializer, the far-end counterpart of the team's 10-bit transmit shift register. It samples an asynchronous serial line and reassembles 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1. It presents each completed byte with a one-cycle valid strobe and flags framing errors. It sits between the board RX pin and the byte consumer (display/command decoder).

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 4.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
data_out  output  8  last correctly framed byte
data_valid  output  1  one-cycle strobe, new byte on data_out
frame_err  output  1  one-cycle strobe, stop bit sampled 0
parity_err  output  1  one-cycle strobe, parity mismatch (see Optional Feature)
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Clocking and reset: reset is synchronous and active-high; clock is clk. All state is registered on posedge clk.
- Reset values:
  - data_out = 8'h00; data_valid, frame_err, parity_err, busy = 0.
  - Both synchronizer flops = 1; state = IDLE; armed = 0; bit counter = 0; cycle counter = 0.
- Input synchronizer: rx passes through 2 flops. rx_s is the second flop, so it lags the pin by 2 cycles. All decisions use rx_s only.
- H = CLKS_PER_BIT/2 (integer division). The cycle counter is wide enough for CLKS_PER_BIT-1.
- Arming: in IDLE, armed is set when rx_s == 1. A start is only accepted while armed, so a held-low line (break or after a frame error) never retriggers until the line returns high.
- State machine:
  - IDLE: if armed and rx_s == 0 -> START, counter = 0, armed = 0.
  - START: when counter == H-1, sample rx_s.
    - 0 -> DATA, counter = 0, bit index = 0.
    - 1 (glitch) -> IDLE, no strobe.
  - DATA: when counter == CLKS_PER_BIT-1, shift rx_s into bit[index] (LSB first) and clear counter.
    - After index 7 -> STOP (or PARITY when enabled).
  - STOP: when counter == CLKS_PER_BIT-1, sample rx_s.
    - 1 -> data_out = shift register, data_valid = 1.
    - 0 -> frame_err = 1, data_out unchanged.
    - Either way -> IDLE. Armed re-evaluates from the next cycle.
- Sample points relative to the cycle rx_s first reads 0 (cycle 0):
  - start verified at cycle H;
  - data bit k sampled at cycle H + (k+1)*CLKS_PER_BIT;
  - stop sampled at cycle H + 9*CLKS_PER_BIT.
- Strobe timing: strobes are registered and high for exactly the one cycle after the stop sample edge. They are never high simultaneously.
- busy is high from the cycle after START entry through the cycle STOP is left.
- Back-to-back frames: the stop sample occurs mid-stop-bit with rx_s == 1, so the block is re-armed before the next start edge. Zero idle gap between frames is supported.
- Reset mid-frame: the FSM returns to IDLE immediately, the partial byte is discarded and no strobe is issued. The first frame after reset requires rx_s high for at least one cycle (arming).

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1.
  - A PARITY state follows DATA and samples at the next CLKS_PER_BIT boundary, i.e. cycle H + 9*CLKS_PER_BIT.
  - STOP then samples at H + 10*CLKS_PER_BIT.
  - Required: XOR of the 8 data bits and the parity bit == 0.
  - If the stop bit is good but parity fails: parity_err = 1, data_valid = 0, data_out unchanged.
  - If the stop bit is 0: frame_err only.
- Undefined: no PARITY state, 8N1 framing, parity_err tied 0.

Test Plan:
All scenarios use CLKS_PER_BIT = 16.
- Clean byte: idle high, send 0xA5 (8N1) -> data_out = 0xA5; data_valid high exactly 1 cycle, 2+8+144+1 cycles after the rx falling edge; frame_err = 0.
- Start glitch: rx low for 4 cycles, then high -> no strobes; busy drops after the START check at cycle 8; a following 0x3C is received correctly.
- Framing error: send 0x5A with stop bit 0, then hold rx low for 40 bits -> frame_err 1 cycle; data_out retains the previous 0xA5; no new frame starts until rx returns high.
- Back-to-back: 0x00 then 0xFF, 0x81 with zero idle gaps -> three data_valid strobes, data_out = 0x00, 0xFF, 0x81 in order.
- Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0xC3 -> all outputs return to reset values with no strobe; the next 0x7E is received.
- Parity (macro defined): 0x03 with parity 0 -> data_valid, data_out = 0x03; 0x03 with parity 1 -> parity_err 1 cycle, data_out unchanged.
